// File: rtl/pwm_duty_scheduler.sv
// Duty scheduler for the LED PWM engine: manual level stepping or automatic breathing.
// Level updates one cycle after a press; compare value commits one cycle after the next period boundary.
// No backpressure: button and period_start pulses are consumed in the cycle they arrive.
//
// Ports:
//   clk, reset_n           - clock; asynchronous active-high reset
//   btn_up_i, btn_down_i   - single-cycle pulses: raise / lower level (manual mode only)
//   btn_mode_i             - single-cycle pulse: toggle manual / breathe
//   period_start_i         - first cycle of each PWM period
//   duty_num_o             - registered compare value for the PWM engine
//   duty_load_o            - one-cycle pulse, duty_num_o changed this cycle
//   level_idx_o            - current target level 0..4
//   mode_o                 - 0 manual, 1 breathe up, 2 breathe down
module pwm_duty_scheduler #(
  parameter int PERIOD       = 200,
  parameter int STEP_PERIODS = 250,
  parameter int DW           = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          btn_up_i,
  input  logic          btn_down_i,
  input  logic          btn_mode_i,
  input  logic          period_start_i,
  output logic [DW-1:0] duty_num_o,
  output logic          duty_load_o,
  output logic [2:0]    level_idx_o,
  output logic [1:0]    mode_o
);

  typedef enum logic [1:0] {
    MANUAL       = 2'd0,
    BREATHE_UP   = 2'd1,
    BREATHE_DOWN = 2'd2
  } mode_t;

  localparam int SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_PERIODS - 1);
  localparam logic [2:0]    LVL_MAX   = 3'd4;

  mode_t          mode_q, mode_d;
  logic [2:0]     level_q, level_d;
  logic [SW-1:0]  step_q, step_d;
  logic           pending_q, pending_d;
  logic [DW-1:0]  duty_q, duty_d;
  logic           load_q, load_d;

  function automatic logic [DW-1:0] lvl_duty(input logic [2:0] idx);
    case (idx)
      3'd0:    lvl_duty = DW'(PERIOD / 20);
      3'd1:    lvl_duty = DW'(PERIOD / 4);
      3'd2:    lvl_duty = DW'(PERIOD / 2);
      3'd3:    lvl_duty = DW'((PERIOD * 3) / 4);
      default: lvl_duty = DW'(PERIOD);
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      mode_q    <= MANUAL;
      level_q   <= LVL_MAX;
      step_q    <= '0;
      pending_q <= 1'b0;
      duty_q    <= DW'(PERIOD);
      load_q    <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      level_q   <= level_d;
      step_q    <= step_d;
      pending_q <= pending_d;
      duty_q    <= duty_d;
      load_q    <= load_d;
    end
  end

  always_comb begin
    mode_d    = mode_q;
    level_d   = level_q;
    step_d    = step_q;
    pending_d = pending_q;
    duty_d    = duty_q;
    load_d    = 1'b0;

    if (btn_mode_i) begin
      // Mode toggle wins over every other input this cycle.
      step_d = '0;
      if (mode_q == MANUAL) begin
        mode_d = (level_q == LVL_MAX) ? BREATHE_DOWN : BREATHE_UP;
      end else begin
        mode_d = MANUAL;
      end
    end else if (mode_q == MANUAL) begin
      // Simultaneous up+down cancel out; saturated presses leave the level alone.
      if (btn_up_i && !btn_down_i && level_q != LVL_MAX) begin
        level_d = level_q + 3'd1;
      end else if (btn_down_i && !btn_up_i && level_q != 3'd0) begin
        level_d = level_q - 3'd1;
      end
    end else if (period_start_i) begin
      if (step_q == STEP_LAST) begin
        step_d = '0;
        if (mode_q == BREATHE_UP) begin
          if (level_q != LVL_MAX) level_d = level_q + 3'd1;
          if (level_d == LVL_MAX) mode_d = BREATHE_DOWN;
        end else begin
          if (level_q != 3'd0) level_d = level_q - 3'd1;
          if (level_d == 3'd0) mode_d = BREATHE_UP;
        end
      end else begin
        step_d = step_q + 1'b1;
      end
    end

    // Commit uses the registered level, so a change in this same cycle
    // waits for the following boundary.
    if (period_start_i && pending_q) begin
      duty_d = lvl_duty(level_q);
      load_d = 1'b1;
    end

    if (level_d != level_q) begin
      pending_d = 1'b1;
    end else if (period_start_i) begin
      pending_d = 1'b0;
    end
  end

  assign duty_num_o  = duty_q;
  assign duty_load_o = load_q;
  assign level_idx_o = level_q;
  assign mode_o      = mode_q;

endmodule

// File: tb/tb_pwm_duty_scheduler.sv
module tb_pwm_duty_scheduler;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_mode = 1'b0, period_start = 1'b0;
  logic [7:0] duty_num;
  logic       duty_load;
  logic [2:0] level_idx;
  logic [1:0] mode;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pwm_duty_scheduler #(.PERIOD(200), .STEP_PERIODS(2), .DW(8)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .btn_up_i      (btn_up),
    .btn_down_i    (btn_down),
    .btn_mode_i    (btn_mode),
    .period_start_i(period_start),
    .duty_num_o    (duty_num),
    .duty_load_o   (duty_load),
    .level_idx_o   (level_idx),
    .mode_o        (mode)
  );

  typedef struct packed {
    logic       up, dn, md, ps;
    logic [2:0] lvl;
    logic [1:0] mode;
    logic [7:0] duty;
    logic       load;
  } vec_t;

  vec_t vecs [22];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int lvl, input int md, input int dty, input int ld);
    chk({tag, ".level"}, int'(level_idx), lvl);
    chk({tag, ".mode"},  int'(mode),      md);
    chk({tag, ".duty"},  int'(duty_num),  dty);
    chk({tag, ".load"},  int'(duty_load), ld);
  endtask

  // One clock: inputs driven at negedge, outputs sampled 1 ns after the rising edge.
  task automatic cyc(input logic up, input logic dn, input logic md, input logic ps);
    @(negedge clk);
    btn_up = up; btn_down = dn; btn_mode = md; period_start = ps;
    @(posedge clk);
    #1;
    btn_up = 0; btn_down = 0; btn_mode = 0; period_start = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk_all("reset", 4, 0, 200, 0);
    @(negedge clk);
    reset_n = 1'b0;
  endtask

  int exp_lvl  [15] = '{2, 3, 3, 4, 4, 3, 3, 2, 2, 1, 1, 0, 0, 1, 1};
  int exp_mode [15] = '{1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 2, 1, 1, 1, 1};
  int exp_duty [15] = '{100, 100, 150, 150, 200, 200, 150, 150, 100, 100, 50, 50, 10, 10, 50};
  int exp_load [15] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

  initial begin
    //                up dn md ps  lvl mode duty load
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 2'd0, 8'd200, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 2'd0, 8'd200, 1'b0}; // saturated up
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 2'd0, 8'd200, 1'b0}; // no pending, no load
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 2'd0, 8'd200, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 2'd0, 8'd200, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 2'd0, 8'd200, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 2'd0, 8'd200, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 2'd0, 8'd50,  1'b1}; // latest level only
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 2'd0, 8'd50,  1'b0}; // single pulse
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 2'd0, 8'd50,  1'b0}; // pending cleared
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 8'd50,  1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 8'd50,  1'b0}; // saturated down
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd0, 8'd10,  1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 8'd10,  1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 8'd10,  1'b0}; // saturated, no pending
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd0, 8'd10,  1'b0};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 8'd10,  1'b0}; // up+down cancel
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd0, 8'd10,  1'b0};
    vecs[18] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd1, 8'd10,  1'b0}; // mode beats up
    vecs[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd1, 8'd10,  1'b0}; // up ignored in breathe
    vecs[20] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 8'd10,  1'b0};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd0, 8'd10,  1'b0};

    do_reset();

    for (int i = 0; i < 22; i++) begin
      cyc(vecs[i].up, vecs[i].dn, vecs[i].md, vecs[i].ps);
      chk_all($sformatf("vec%0d", i), int'(vecs[i].lvl), int'(vecs[i].mode),
              int'(vecs[i].duty), int'(vecs[i].load));
    end

    // Breathe from level 2 with two periods per step.
    do_reset();
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1);
    chk_all("brth_pre", 2, 0, 100, 1);
    cyc(0, 0, 1, 0);
    chk_all("brth_enter", 2, 1, 100, 0);
    for (int k = 0; k < 15; k++) begin
      repeat (3) cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 1);
      chk_all($sformatf("brth_ps%0d", k + 1), exp_lvl[k], exp_mode[k], exp_duty[k], exp_load[k]);
    end

    // Level change in the same cycle as a committing boundary.
    cyc(0, 0, 1, 0);
    chk_all("coin_manual", 1, 0, 50, 0);
    cyc(1, 0, 0, 0);
    chk_all("coin_up", 2, 0, 50, 0);
    cyc(1, 0, 0, 1);
    chk_all("coin_commit_old", 3, 0, 100, 1);
    cyc(0, 0, 0, 0);
    chk_all("coin_gap", 3, 0, 100, 0);
    cyc(0, 0, 0, 1);
    chk_all("coin_commit_new", 3, 0, 150, 1);
    cyc(0, 0, 0, 1);
    chk_all("coin_idle", 3, 0, 150, 0);

    // Asynchronous reset mid-breathe with a pending step.
    cyc(0, 0, 1, 0);
    chk_all("ar_enter", 3, 1, 150, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk_all("ar_step", 4, 2, 150, 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    #1;
    chk_all("ar_async", 4, 0, 200, 0);
    @(negedge clk);
    reset_n = 1'b0;
    cyc(0, 0, 0, 1);
    chk_all("ar_post_ps1", 4, 0, 200, 0);
    cyc(0, 0, 0, 1);
    chk_all("ar_post_ps2", 4, 0, 200, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1);
    chk_all("ar_new_change", 3, 0, 150, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_duty_scheduler.md
Name: pwm_duty_scheduler

Overview:
Controller that sequences the duty setting of the LED PWM engine.
- Two operating modes: manual brightness stepping from debounced button pulses, and automatic "breathing" that ramps through the five brightness levels up and down.
- Sits between the button debouncers and the PWM generator.
- Drives a new compare value only at PWM period boundaries, so the engine never sees a mid-period change.

Parameters:
- PERIOD, 200, PWM period length in clk cycles; also the full-scale duty value.
- STEP_PERIODS, 250, number of PWM periods spent on each level in breathe mode (≥1).
- DW, 8, width of duty_num; must hold PERIOD.

Ports:
- clk  in  1  system clock, 100 MHz
- reset_n  in  1  asynchronous reset, active-high
- btn_up  in  1  debounced single-cycle pulse: raise level (manual mode)
- btn_down  in  1  debounced single-cycle pulse: lower level (manual mode)
- btn_mode  in  1  debounced single-cycle pulse: toggle manual/breathe
- period_start  in  1  one-cycle pulse from PWM engine at the first cycle of each period
- duty_num  out  DW  active compare value for the PWM engine (registered)
- duty_load  out  1  one-cycle pulse; duty_num changed this cycle
- level_idx  out  3  current target level, 0..4
- mode  out  2  0=MANUAL, 1=BREATHE_UP, 2=BREATHE_DOWN

Behaviour:
- Reset is asynchronous and active-high. Values on reset:
  - level_idx=4, duty_num=PERIOD, duty_load=0, mode=MANUAL
  - pending=0, step_cnt=0
  - Reset mid-ramp or mid-pending discards all state.
- Level table, integer arithmetic truncated:
  - L0=PERIOD/20, L1=PERIOD/4, L2=PERIOD/2, L3=(PERIOD*3)/4, L4=PERIOD.
  - With PERIOD=200: 10, 50, 100, 150, 200.
- Input priority per cycle: btn_mode > (btn_up XOR btn_down). If btn_up and btn_down are both high in the same cycle, both are ignored.
- MANUAL mode:
  - btn_up: level_idx+1, saturating at 4.
  - btn_down: level_idx-1, saturating at 0.
  - A saturated press is no change and sets no pending.
- btn_mode transitions:
  - MANUAL → BREATHE_UP, or → BREATHE_DOWN if level_idx==4.
  - BREATHE_UP / BREATHE_DOWN → MANUAL, keeping the current level_idx.
  - Every mode change clears step_cnt.
- BREATHE mode:
  - btn_up and btn_down are ignored.
  - step_cnt increments on each period_start.
  - On a period_start with step_cnt==STEP_PERIODS-1: step_cnt←0 and the level steps.
  - BREATHE_UP: level+1. If the new level is 4, mode←BREATHE_DOWN in the same cycle.
  - BREATHE_DOWN: level-1. If the new level is 0, mode←BREATHE_UP in the same cycle.
- Any actual level change sets pending=1. The latest level wins; intermediate levels are never loaded.
- Commit:
  - On a period_start cycle with pending=1: duty_num←table[registered level_idx] and duty_load=1 on the next cycle.
  - pending clears unless a level change occurs in that same cycle; set has priority, so the new level commits at the following boundary.
  - A breathe step therefore reaches duty_num one full period after its boundary.
- Latency: a manual press in cycle t updates level_idx at t+1. duty_num updates on the cycle after the next period_start that follows t.
- duty_load is never asserted without a duty_num change caused by pending. Its pulse width is exactly 1 cycle.
- period_start with pending=0 leaves all outputs unchanged (except the breathe step_cnt).

Test Plan:
- Reset, then 3 btn_down pulses spaced 10 cycles, period_start every 200 cycles → level_idx 4→1. At the next period_start, duty_num=50 and duty_load is a single pulse. No intermediate 150/100 is ever loaded.
- At level 4, btn_up; at level 0, btn_down → level_idx unchanged, pending stays 0, no duty_load at the following boundaries.
- btn_up and btn_down in the same cycle, then btn_mode and btn_up in the same cycle → first: no change; second: mode=1, level unchanged.
- STEP_PERIODS=2, breathe from level 2 → level sequence 3,4,3,2,1,0,1 every 2 periods. Mode flips to 2 in the same cycle level reaches 4, and back to 1 at 0. Each duty_num update lags its step by one period.
- Level change coincident with period_start while pending=1 → old pending value loaded now, pending stays 1, new value loaded at the next boundary.
- Assert reset_n asynchronously mid-breathe with pending=1 → outputs return immediately to level 4, duty_num=200, mode 0; no duty_load after release until a new change.
